rv32i_inst_encoder: RTL and testbench

//  Field-level RV32I instruction encoder: the encode direction of the core's decode path.

---
 rtl/rv32i_inst_encoder_pkg.sv | 41 ++++
 rtl/rv32i_encode_core.sv | 117 +++++++++++
 rtl/rv32i_inst_encoder.sv | 135 +++++++++++++
 tb/tb_rv32i_inst_encoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared RV32I encodings for the instruction encoder: opcodes, formats,
// the canonical NOP and a small signed range helper.
package rv32i_inst_encoder_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        fmt_r,
        fmt_i,
        fmt_s,
        fmt_b,
        fmt_u,
        fmt_j
    } inst_fmt_t;

    // addi x0,x0,0 -- emitted in place of any rejected request
    localparam rv32i_word NOP_INST = 32'h0000_0013;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // True when v, read as a two's-complement value, lies in [lo, hi]
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/rv32i_encode_core.sv
// Pure combinational field packer: request fields -> {instruction, illegal}.
// An illegal request always yields the canonical NOP.
module rv32i_encode_core
    import rv32i_inst_encoder_pkg::*;
#(
    parameter bit CHECK_IMM = 1'b1
) (
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_alt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_illegal
);

    logic      w_known;
    logic      w_f3_bad;
    logic      w_alt_ok;
    logic      w_is_shift;
    logic      w_is_csr;
    logic      w_imm_bad;
    logic      w_illegal;
    inst_fmt_t w_fmt;
    rv32i_word w_packed;

    // Classify the opcode: format, funct3 legality and whether bit30 may be set
    always_comb begin
        w_known    = 1'b1;
        w_fmt      = fmt_i;
        w_f3_bad   = 1'b0;
        w_alt_ok   = 1'b0;
        w_is_shift = 1'b0;
        w_is_csr   = 1'b0;
        case (i_opcode)
            op_lui, op_auipc: w_fmt = fmt_u;
            op_jal:           w_fmt = fmt_j;
            op_jalr: begin
                w_fmt    = fmt_i;
                w_f3_bad = (i_funct3 != 3'b000);
            end
            op_br: begin
                w_fmt    = fmt_b;
                w_f3_bad = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            op_load: begin
                w_fmt    = fmt_i;
                w_f3_bad = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
            end
            op_store: begin
                w_fmt    = fmt_s;
                w_f3_bad = (i_funct3 > 3'b010);
            end
            op_imm: begin
                w_fmt      = fmt_i;
                w_is_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
                w_alt_ok   = (i_funct3 == F3_SR);
            end
            op_reg: begin
                w_fmt    = fmt_r;
                w_alt_ok = (i_funct3 == F3_ADD) || (i_funct3 == F3_SR);
            end
            op_csr: begin
                w_fmt    = fmt_i;
                w_is_csr = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // Immediate range/alignment check; a CSR address is an unsigned 12-bit value
    always_comb begin
        w_imm_bad = 1'b0;
        case (w_fmt)
            fmt_i: begin
                if (w_is_shift)
                    w_imm_bad = |i_imm[31:5];
                else if (w_is_csr)
                    w_imm_bad = |i_imm[31:12];
                else
                    w_imm_bad = !in_range(i_imm, -2048, 2047);
            end
            fmt_s:   w_imm_bad = !in_range(i_imm, -2048, 2047);
            fmt_b:   w_imm_bad = i_imm[0] || !in_range(i_imm, -4096, 4094);
            fmt_u:   w_imm_bad = |i_imm[11:0];
            fmt_j:   w_imm_bad = i_imm[0] || !in_range(i_imm, -(1 << 20), (1 << 20) - 2);
            default: w_imm_bad = 1'b0;
        endcase
    end

    // Scatter the fields into the instruction word for the selected format
    always_comb begin
        w_packed = NOP_INST;
        case (w_fmt)
            fmt_r: w_packed = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            fmt_i: begin
                if (w_is_shift)
                    w_packed = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                else
                    w_packed = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            fmt_s: w_packed = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            fmt_b: w_packed = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_opcode};
            fmt_u: w_packed = {i_imm[31:12], i_rd, i_opcode};
            fmt_j: w_packed = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default: w_packed = NOP_INST;
        endcase
    end

    assign w_illegal = !w_known || w_f3_bad || (i_alt && !w_alt_ok) || (CHECK_IMM && w_imm_bad);
    assign o_illegal = w_illegal;
    assign o_inst    = w_illegal ? NOP_INST : w_packed;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: valid/ready request side, small strict-order
// output FIFO of {inst, illegal}, and saturating delivered-word statistics.
module rv32i_inst_encoder
    import rv32i_inst_encoder_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16,
    parameter bit CHECK_IMM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_illegal,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_FW-1:0]       r_count;
    logic                    r_ready_en;
    logic [CNT_W-1:0]        r_enc_count;
    logic [CNT_W-1:0]        r_err_count;
    logic [DEPTH-1:0][32:0]  w_slot;
    logic [32:0]             w_head;
    logic [31:0]             w_enc_inst;
    logic                    w_enc_illegal;
    logic                    w_push;
    logic                    w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    rv32i_encode_core #(
        .CHECK_IMM (CHECK_IMM)
    ) u_core (
        .i_opcode  (in_opcode),
        .i_funct3  (in_funct3),
        .i_alt     (in_alt),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .o_inst    (w_enc_inst),
        .o_illegal (w_enc_illegal)
    );

    // Full FIFO refuses a push even when the head is popped in the same cycle
    assign in_ready  = r_ready_en && (r_count < CNT_FW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [32:0] r_entry;

            // Capture the encoded request when this slot is the tail
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_entry <= '0;
                else if (w_push && (r_tail == PTR_W'(gi)))
                    r_entry <= {w_enc_inst, w_enc_illegal};
            end

            assign w_slot[gi] = r_entry;
        end
    endgenerate

    assign w_head      = w_slot[r_head];
    assign out_inst    = out_valid ? w_head[32:1] : '0;
    assign out_illegal = out_valid && w_head[0];
    assign enc_count   = r_enc_count;
    assign err_count   = r_err_count;

    // Hold off acceptance until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_ready_en <= 1'b0;
        else
            r_ready_en <= 1'b1;
    end

    // Head/tail pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= ptr_inc(r_tail);
            if (w_pop)
                r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Delivered-word statistics, counted on pop and held at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_pop) begin
            if (w_head[0]) begin
                if (r_err_count != '1)
                    r_err_count <= r_err_count + 1'b1;
            end else begin
                if (r_enc_count != '1)
                    r_enc_count <= r_enc_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Bench for rv32i_inst_encoder: directed encodings, backpressure and reset,
// then randomized traffic against an arithmetic reference encoder.
module tb_rv32i_inst_encoder;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [2:0]       in_funct3 = '0;
    logic             in_alt = 1'b0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic             out_illegal;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_enc  = 0;
    int exp_err  = 0;

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    int edges [16] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095,
                       1048574, 1048576, -1048576, -1048578, 31, 32, 4096, 'h12345000};

    always #5 clk = ~clk;

    rv32i_inst_encoder #(
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .CHECK_IMM (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_alt      (in_alt),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_illegal (out_illegal),
        .enc_count   (enc_count),
        .err_count   (err_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        in_opcode = op;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic count_pop(input logic ill);
        if (ill) exp_err = (exp_err < CNT_MAX) ? exp_err + 1 : exp_err;
        else     exp_enc = (exp_enc < CNT_MAX) ? exp_enc + 1 : exp_enc;
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "/enc_count"}, 32'(enc_count), 32'(exp_enc));
        check_val({tag, "/err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    // Reference encoder: field placement by shifts/masks, legality from the rule list
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                            input logic alt, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        int          s;
        bit          bad;
        logic [31:0] w, rdf, r1, r2, f, base, alt30, itype;
        s     = int'($signed(imm));
        base  = 32'(op);
        rdf   = 32'(rd) << 7;
        r1    = 32'(rs1) << 15;
        r2    = 32'(rs2) << 20;
        f     = 32'(f3) << 12;
        alt30 = alt ? 32'h4000_0000 : 32'h0;
        itype = ((imm & 32'hFFF) << 20) | r1 | f | rdf | base;
        bad   = 1'b0;
        w     = 32'h0;
        case (op)
            7'h37, 7'h17: begin
                bad = alt || ((imm & 32'hFFF) != 0);
                w   = (imm & 32'hFFFF_F000) | rdf | base;
            end
            7'h6F: begin
                bad = alt || (s % 2 != 0) || (s < -1048576) || (s > 1048574);
                w   = (32'(imm[20]) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (32'(imm[11]) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdf | base;
            end
            7'h67: begin
                bad = alt || (f3 != 0) || (s < -2048) || (s > 2047);
                w   = itype;
            end
            7'h63: begin
                bad = alt || (f3 inside {3'd2, 3'd3}) || (s % 2 != 0) || (s < -4096) || (s > 4094);
                w   = (32'(imm[12]) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f |
                      (((imm >> 1) & 32'hF) << 8) | (32'(imm[11]) << 7) | base;
            end
            7'h03: begin
                bad = alt || (f3 inside {3'd3, 3'd6, 3'd7}) || (s < -2048) || (s > 2047);
                w   = itype;
            end
            7'h23: begin
                bad = alt || (f3 > 2) || (s < -2048) || (s > 2047);
                w   = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((imm & 32'h1F) << 7) | base;
            end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    bad = (alt && f3 == 1) || (imm > 31);
                    w   = alt30 | ((imm & 32'h1F) << 20) | r1 | f | rdf | base;
                end else begin
                    bad = alt || (s < -2048) || (s > 2047);
                    w   = itype;
                end
            end
            7'h33: begin
                bad = alt && !(f3 inside {3'd0, 3'd5});
                w   = alt30 | r2 | r1 | f | rdf | base;
            end
            7'h73: begin
                bad = alt || (imm > 4095);
                w   = itype;
            end
            default: bad = 1'b1;
        endcase
        return bad ? {32'h0000_0013, 1'b1} : {w, 1'b0};
    endfunction

    function automatic logic [31:0] rand_imm();
        case ($urandom % 5)
            0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       return 32'(edges[$urandom % 16]);
            2:       return 32'($urandom);
            3:       return 32'($urandom) & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 40));
        endcase
    endfunction

    // One request through an empty FIFO: visible the cycle after acceptance, then popped
    task automatic send_chk(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_ill);
        set_req(op, f3, alt, rd, rs1, rs2, imm);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        check_val({tag, "/valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "/inst"}, out_inst, exp_inst);
        check_val({tag, "/illegal"}, 32'(out_illegal), 32'(exp_ill));
        $display("txn %s: inst=%08h illegal=%0b", tag, out_inst, out_illegal);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        count_pop(exp_ill);
        check_counts(tag);
    endtask

    logic [32:0] q[$];
    logic [32:0] e;
    int          pre;
    bit          do_pop, do_push;
    int          n_txn = 0;

    initial begin
        // Reset state
        cyc();
        cyc();
        check_val("rst/in_ready", 32'(in_ready), 32'd0);
        check_val("rst/out_valid", 32'(out_valid), 32'd0);
        check_val("rst/out_inst", out_inst, 32'd0);
        check_val("rst/out_illegal", 32'(out_illegal), 32'd0);
        check_counts("rst");
        rst = 1'b1;
        #1;
        check_val("rel/in_ready_before_edge", 32'(in_ready), 32'd0);
        cyc();
        check_val("rel/in_ready_after_edge", 32'(in_ready), 32'd1);

        // Directed encodings
        send_chk("addi", 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        send_chk("sub", 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
        send_chk("lui", 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send_chk("beq_m8", 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_8CE3, 1'b0);
        send_chk("beq_m7", 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd7, 32'h0000_0013, 1'b1);
        send_chk("br_f3_2", 7'h63, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0000_0013, 1'b1);
        send_chk("st_f3_3", 7'h23, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 32'h0000_0013, 1'b1);
        send_chk("addi_alt", 7'h13, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0000_0013, 1'b1);

        // Backpressure: two accepted, third waits until a slot frees
        out_ready = 1'b0;
        set_req(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1;
        check_val("bp/ready0", 32'(in_ready), 32'd1);
        cyc();
        check_val("bp/ready1", 32'(in_ready), 32'd1);
        check_val("bp/head1", out_inst, 32'h0010_0093);
        in_imm = 32'd2;
        cyc();
        check_val("bp/ready_full", 32'(in_ready), 32'd0);
        in_imm = 32'd3;
        cyc();
        check_val("bp/ready_held", 32'(in_ready), 32'd0);
        check_val("bp/head_stable", out_inst, 32'h0010_0093);
        out_ready = 1'b1;
        cyc();
        check_val("bp/head2", out_inst, 32'h0020_0093);
        check_val("bp/ready_after_pop", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check_val("bp/head3", out_inst, 32'h0030_0093);
        check_val("bp/valid3", 32'(out_valid), 32'd1);
        cyc();
        check_val("bp/drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        count_pop(1'b0);
        count_pop(1'b0);
        count_pop(1'b0);
        check_counts("bp");
        $display("txn backpressure: 3 words delivered in order");

        // Mid-stream reset with two entries queued
        set_req(7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd9);
        in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        check_val("mid/queued_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        exp_enc = 0;
        exp_err = 0;
        check_val("mid/out_valid", 32'(out_valid), 32'd0);
        check_val("mid/out_inst", out_inst, 32'd0);
        check_val("mid/in_ready", 32'(in_ready), 32'd0);
        check_counts("mid");
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        check_val("mid/no_replay", 32'(out_valid), 32'd0);
        check_val("mid/ready_back", 32'(in_ready), 32'd1);
        $display("txn reset: queue flushed");

        // Randomized traffic against the reference encoder
        for (int c = 0; c < 600; c++) begin
            check_val("rnd/out_valid", 32'(out_valid), 32'(q.size() != 0));
            check_val("rnd/in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            if (q.size() > 0) begin
                check_val("rnd/inst", out_inst, q[0][32:1]);
                check_val("rnd/illegal", 32'(out_illegal), 32'(q[0][0]));
            end
            check_counts("rnd");

            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            set_req((($urandom % 8) == 0) ? 7'($urandom) : ops[$urandom % 10],
                    3'($urandom), ($urandom % 4) == 0, 5'($urandom), 5'($urandom),
                    5'($urandom), rand_imm());

            pre     = q.size();
            do_pop  = out_ready && (pre > 0);
            do_push = in_valid && (pre < DEPTH);
            if (do_pop) begin
                e = q.pop_front();
                count_pop(e[0]);
                n_txn++;
                $display("txn %0d: inst=%08h illegal=%0b", n_txn, e[32:1], e[0]);
            end
            if (do_push)
                q.push_back(ref_enc(in_opcode, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm));
            cyc();
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
